// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Register map on Addr[3:2]: 0 DATA (W), 1 CTRL (RW), 2 STATUS (R, write clears sticky bits),
// 3 DIV (RW, cycles per bit, 0 acts as 1).
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit enabled by CTRL[1].
module uart_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegCtrl   = 2'd1;
    localparam logic [1:0] RegStatus = 2'd2;
    localparam logic [1:0] RegDiv    = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic wr_data;
    logic wr_ctrl;
    logic wr_status;
    logic wr_div;

    assign wr_data   = WE && (Addr[3:2] == RegData);
    assign wr_ctrl   = WE && (Addr[3:2] == RegCtrl);
    assign wr_status = WE && (Addr[3:2] == RegStatus);
    assign wr_div    = WE && (Addr[3:2] == RegDiv);

    // Upper address bits are decoded by the bridge; upper data bits have no home.
    logic unused_bits;
    assign unused_bits = ^{Addr[31:4], Din[31:16]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [7:0]      fifo_head;

    assign fifo_full  = (count_q == DepthCnt);
    assign fifo_empty = (count_q == '0);
    // Fullness is judged on the start-of-cycle count, even if the FSM pops this cycle.
    assign push       = wr_data && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr_q];

    // FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= Din[7:0];
        end
    end

    // FIFO pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic        ie_q;
    logic        pe_rd;
    logic [15:0] div_q;
    logic        done_q;
    logic        done_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        frame_done;
`ifdef UART_TX_PARITY_EN
    logic        pe_q;
    assign pe_rd = pe_q;
`else
    assign pe_rd = 1'b0;
`endif

    // Sticky flags: an accepted push or any STATUS write wins over a same-cycle set.
    always_comb begin
        done_d = done_q;
        ovf_d  = ovf_q;
        if (frame_done) begin
            done_d = 1'b1;
        end
        if (push || wr_status) begin
            done_d = 1'b0;
        end
        if (wr_data && fifo_full) begin
            ovf_d = 1'b1;
        end
        if (wr_status) begin
            ovf_d = 1'b0;
        end
    end

    // CPU-visible configuration and sticky status bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q   <= 1'b0;
            div_q  <= DIV_RESET;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            pe_q   <= 1'b0;
`endif
        end else begin
            if (wr_ctrl) begin
                ie_q <= Din[0];
`ifdef UART_TX_PARITY_EN
                pe_q <= Din[1];
`endif
            end
            if (wr_div) begin
                div_q <= Din[15:0];
            end
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign IRQ = ie_q & done_q;

    // ------------------------------------------------------------------
    // Transmit FSM and baud timing
    // ------------------------------------------------------------------
    state_e      state_q;
    state_e      state_d;
    logic [15:0] baud_cnt_q;
    logic [15:0] baud_cnt_d;
    logic [15:0] bit_div_q;
    logic [15:0] bit_div_d;
    logic [2:0]  bit_cnt_q;
    logic [2:0]  bit_cnt_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        txd_q;
    logic        txd_d;
    logic [15:0] div_eff;
    logic        bit_end;
    logic        busy;
`ifdef UART_TX_PARITY_EN
    logic        par_q;
    logic        par_d;
    logic        frame_pe_q;
    logic        frame_pe_d;
`endif

    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    // bit_div_q holds the divisor latched at the start of the current bit (always >= 1).
    assign bit_end = (baud_cnt_q == (bit_div_q - 16'd1));
    assign busy    = (state_q != StIdle);

    // Next-state logic, FIFO pop request and registered serial output value.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_div_d  = bit_div_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        txd_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
        frame_pe_d = frame_pe_q;
`endif

        case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d    = StData;
                    baud_cnt_d = '0;
                    bit_div_d  = div_eff;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_div_d  = div_eff;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = frame_pe_q ? StParity : StStop;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d    = StStop;
                    baud_cnt_d = '0;
                    bit_div_d  = div_eff;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop = 1'b1;
                    end else begin
                        state_d    = StIdle;
                        frame_done = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Frame start: load the head byte and latch per-frame settings.
        if (pop) begin
            state_d    = StStart;
            baud_cnt_d = '0;
            bit_div_d  = div_eff;
            bit_cnt_d  = '0;
            shift_d    = fifo_head;
`ifdef UART_TX_PARITY_EN
            par_d      = ^fifo_head;
            frame_pe_d = pe_q;
`endif
        end

        // Serial value for the state being entered, so txd is glitch-free.
        case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // FSM state, baud timing and output register; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_div_q  <= 16'd1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
            frame_pe_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_div_q  <= bit_div_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
            frame_pe_q <= frame_pe_d;
`endif
        end
    end

    assign txd = txd_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [3:0] cnt_field;
    // Count field is 4 bits wide; a full 16-deep FIFO wraps to 0 here (full flag still set).
    assign cnt_field = 4'(count_q);

    // Combinational register read-back.
    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            RegCtrl:   Dout[1:0]  = {pe_rd, ie_q};
            RegStatus: Dout[11:0] = {cnt_field, 3'b000, ovf_q, done_q, fifo_empty, fifo_full, busy};
            RegDiv:    Dout[15:0] = div_q;
            default:   Dout       = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Expected serial waveforms come from a bit-list model of
// an 8N1 (optionally even-parity) frame; FIFO acceptance from a simple occupancy count.
module tb_uart_tx;

    localparam int unsigned Depth    = 8;
    localparam logic [15:0] DivReset = 16'd434;
`ifdef UART_TX_PARITY_EN
    localparam bit HasParity = 1'b1;
`else
    localparam bit HasParity = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:2] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .FIFO_DEPTH(Depth),
        .DIV_RESET (DivReset)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ),
        .txd  (txd)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; write lands on the next posedge; returns at the following negedge.
    task automatic bus_write(input logic [1:0] reg_idx, input logic [31:0] data);
        Addr       = '0;
        Addr[31:4] = 28'($urandom);
        Addr[3:2]  = reg_idx;
        Din        = data;
        WE         = 1'b1;
        @(negedge clk);
        WE         = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] reg_idx, output logic [31:0] data);
        Addr       = '0;
        Addr[31:4] = 28'($urandom);
        Addr[3:2]  = reg_idx;
        #1;
        data = Dout;
    endtask

    // Starts at the negedge after the pop edge; ends at the negedge after the stop bit ends.
    // Optionally writes DIV=wr_div from the sample point wr_at (>=0).
    task automatic check_frame(input logic [7:0] b, input int d0, input int d1, input bit pe,
                               input int wr_at, input logic [15:0] wr_div, input string name);
        logic bits[$];
        int   k;
        int   dur;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (pe) bits.push_back(^b);
        bits.push_back(1'b1);
        k = 0;
        for (int i = 0; i < bits.size(); i++) begin
            dur = (i == 0) ? d0 : d1;
            for (int c = 0; c < dur; c++) begin
                tests_run++;
                if ({txd, IRQ} !== {bits[i], 1'b0}) begin
                    tests_failed++;
                    $display("FAIL %s bit %0d cycle %0d: txd,IRQ=%b%b expected %b0",
                             name, i, c, txd, IRQ, bits[i]);
                end
                if (wr_at >= 0 && k == wr_at) begin
                    Addr      = '0;
                    Addr[3:2] = 2'd3;
                    Din       = {16'h0, wr_div};
                    WE        = 1'b1;
                end else if (wr_at >= 0 && k == wr_at + 1) begin
                    WE = 1'b0;
                end
                k++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1;
        WE    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus_read(2'd0, r);
        tests_run++;
        if (r !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", r); end
        bus_read(2'd1, r);
        tests_run++;
        if (r !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h expected 0", r); end
        bus_read(2'd2, r);
        tests_run++;
        if (r !== 32'h4) begin tests_failed++; $display("FAIL reset_status: got %h expected 4", r); end
        bus_read(2'd3, r);
        tests_run++;
        if (r !== 32'(DivReset)) begin
            tests_failed++; $display("FAIL reset_div: got %h expected %h", r, DivReset);
        end
        tests_run++;
        if ({txd, IRQ} !== 2'b10) begin
            tests_failed++; $display("FAIL reset_pins: txd,IRQ=%b%b expected 10", txd, IRQ);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] r;
        bus_write(2'd3, 32'd4);
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'hA5);
        bus_read(2'd2, r);
        tests_run++;
        if (r !== 32'h100) begin tests_failed++; $display("FAIL basic_queued: got %h expected 100", r); end
        @(negedge clk);
        bus_read(2'd2, r);
        tests_run++;
        if (r !== 32'h5) begin tests_failed++; $display("FAIL basic_popped: got %h expected 5", r); end
        check_frame(8'hA5, 4, 4, 1'b0, -1, 16'd0, "basic");
        bus_read(2'd2, r);
        tests_run++;
        if (r !== 32'hC || IRQ !== 1'b1) begin
            tests_failed++; $display("FAIL basic_done: status=%h IRQ=%b expected c,1", r, IRQ);
        end
        bus_write(2'd2, 32'h0);
        bus_read(2'd2, r);
        tests_run++;
        if (r !== 32'h4 || IRQ !== 1'b0) begin
            tests_failed++; $display("FAIL basic_clear: status=%h IRQ=%b expected 4,0", r, IRQ);
        end
    endtask

    task automatic test_fifo_burst();
        int          n;
        int          cnt;
        bit          exp_ovf;
        logic [7:0]  bytes[$];
        logic [7:0]  acc_q[$];
        logic [31:0] r;
        logic [31:0] exp;
        n = $urandom_range(9, 11);
        for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
        // Occupancy model: accept if count < Depth; the first byte pops on the 2nd write edge.
        cnt     = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (cnt < Depth) begin
                acc_q.push_back(bytes[i]);
                cnt++;
            end else begin
                exp_ovf = 1'b1;
            end
            if (i == 1) cnt--;
        end
        bus_write(2'd3, 32'd2);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    Addr      = '0;
                    Addr[3:2] = 2'd0;
                    Din       = {24'($urandom), bytes[i]};
                    WE        = 1'b1;
                    @(negedge clk);
                end
                WE = 1'b0;
            end
            begin
                @(negedge clk);
                @(negedge clk);
                for (int j = 0; j < acc_q.size(); j++) begin
                    if (j > 0) begin
                        cnt = acc_q.size() - 1 - j;
                        exp = (32'(cnt) << 8) | 32'h1 | ((cnt == 0) ? 32'h4 : 32'h0);
                        bus_read(2'd2, r);
                        tests_run++;
                        if (r !== exp) begin
                            tests_failed++;
                            $display("FAIL burst_status%0d: got %h expected %h", j, r, exp);
                        end
                    end
                    check_frame(acc_q[j], 2, 2, 1'b0, -1, 16'd0, $sformatf("burst%0d", j));
                end
            end
        join
        exp = 32'hC | (exp_ovf ? 32'h10 : 32'h0);
        bus_read(2'd2, r);
        tests_run++;
        if (r !== exp) begin tests_failed++; $display("FAIL burst_end: got %h expected %h", r, exp); end
        bus_write(2'd2, 32'h0);
        bus_read(2'd2, r);
        tests_run++;
        if (r !== 32'h4) begin tests_failed++; $display("FAIL burst_clear: got %h expected 4", r); end
    endtask

    task automatic test_div_change();
        logic [7:0]  b;
        logic [31:0] r;
        b = 8'($urandom);
        bus_write(2'd3, 32'd4);
        bus_write(2'd0, {24'h0, b});
        @(negedge clk);
        check_frame(b, 4, 8, 1'b0, $urandom_range(0, 2), 16'd8, "div_change");
        bus_read(2'd2, r);
        tests_run++;
        if (r !== 32'hC) begin tests_failed++; $display("FAIL div_change_done: got %h expected c", r); end
        bus_read(2'd3, r);
        tests_run++;
        if (r !== 32'd8) begin tests_failed++; $display("FAIL div_change_rd: got %h expected 8", r); end
    endtask

    task automatic test_random();
        logic [7:0]  b;
        logic [15:0] d;
        int          eff;
        logic [31:0] r;
        for (int it = 0; it < 4; it++) begin
            b   = 8'($urandom);
            d   = 16'($urandom_range(0, 5));
            eff = (d == 0) ? 1 : int'(d);
            bus_write(2'd3, {16'($urandom), d});
            bus_read(2'd3, r);
            tests_run++;
            if (r !== {16'h0, d}) begin
                tests_failed++; $display("FAIL rand_div%0d: got %h expected %h", it, r, d);
            end
            bus_write(2'd0, {24'h0, b});
            @(negedge clk);
            check_frame(b, eff, eff, 1'b0, -1, 16'd0, $sformatf("rand%0d", it));
            tests_run++;
            if (IRQ !== 1'b1) begin
                tests_failed++; $display("FAIL rand_irq%0d: got %b expected 1", it, IRQ);
            end
        end
    endtask

    task automatic test_parity();
        logic [31:0] r;
        logic [7:0]  vals[2];
        vals[0] = 8'h07;
        vals[1] = 8'($urandom);
        bus_write(2'd1, 32'd3);
        bus_read(2'd1, r);
        tests_run++;
        if (r !== (HasParity ? 32'd3 : 32'd1)) begin
            tests_failed++; $display("FAIL parity_ctrl: got %h expected %0d", r, HasParity ? 3 : 1);
        end
        bus_write(2'd3, 32'd2);
        for (int i = 0; i < 2; i++) begin
            bus_write(2'd0, {24'h0, vals[i]});
            @(negedge clk);
            check_frame(vals[i], 2, 2, HasParity, -1, 16'd0, $sformatf("parity%0d", i));
            bus_read(2'd2, r);
            tests_run++;
            if (r !== 32'hC) begin
                tests_failed++; $display("FAIL parity_done%0d: got %h expected c", i, r);
            end
        end
        bus_write(2'd1, 32'd1);
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  b0;
        logic [31:0] r;
        int          lows;
        b0 = 8'($urandom) & 8'hF7;
        bus_write(2'd3, 32'd4);
        bus_write(2'd0, {24'h0, b0});
        bus_write(2'd0, 32'($urandom_range(0, 255)));
        repeat (17) @(negedge clk);
        tests_run++;
        if (txd !== b0[3]) begin
            tests_failed++; $display("FAIL mid_bit3: txd=%b expected %b", txd, b0[3]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (txd !== 1'b1) begin tests_failed++; $display("FAIL mid_txd: got %b expected 1", txd); end
        bus_read(2'd2, r);
        tests_run++;
        if (r !== 32'h4) begin tests_failed++; $display("FAIL mid_status: got %h expected 4", r); end
        bus_read(2'd3, r);
        tests_run++;
        if (r !== 32'(DivReset)) begin
            tests_failed++; $display("FAIL mid_div: got %h expected %h", r, DivReset);
        end
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        tests_run++;
        if (lows != 0) begin
            tests_failed++; $display("FAIL mid_quiet: %0d low cycles expected 0", lows);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_fifo_burst();
        test_div_change();
        test_random();
        test_parity();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Memory-mapped UART transmitter peripheral that sits downstream of the system bridge, beside the two timers. Reached through its own bridge address window and write-enable. Accepts bytes from CPU stores into a small FIFO and serialises them 8N1 on `txd`. Raises a level interrupt `IRQ`, which the top level wires into the free external-interrupt bit `HWInt[3]`.

## Interface
Parameters:
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..16.
- `DIV_RESET`, 16'd434, reset value of the baud divisor (cycles per bit).

Ports:
- `clk`  input  1  system clock; one clock domain only.
- `reset`  input  1  synchronous, active-high reset.
- `Addr`  input  30  word address `m_data_addr[31:2]`; only `Addr[3:2]` is decoded; the bridge does window decode.
- `WE`  input  1  write strobe from the bridge, already qualified by address window and byteen.
- `Din`  input  32  write data.
- `Dout`  output  32  read data for the selected register; combinational from `Addr[3:2]` and current state.
- `IRQ`  output  1  level interrupt request.
- `txd`  output  1  serial line; idle high.

## Operation
Register map (`Addr[3:2]`):
- 0 `DATA`, W: pushes `Din[7:0]` into the FIFO. Reads 0.
- 1 `CTRL`, RW, bits [1:0]:
  - bit0 `IE`: interrupt enable.
  - bit1 `PE`: parity enable; see Configuration.
  - Other bits read 0.
- 2 `STATUS`, R:
  - [0] busy (FSM not IDLE).
  - [1] full.
  - [2] empty.
  - [3] `DONE`.
  - [4] `OVF`.
  - [11:8] FIFO count.
  - Others 0.
  - Any write clears `DONE` and `OVF`.
- 3 `DIV`, RW [15:0]: cycles per bit. A value of 0 is treated as 1.

FIFO:
- Write is accepted only if count < `FIFO_DEPTH` at the start of the cycle. This holds even if a pop happens in the same cycle.
- A write to a full FIFO is dropped and sets sticky `OVF`.
- Count update: count + push − pop.

FSM states IDLE → START → DATA → [PARITY] → STOP:
- IDLE: if FIFO non-empty, pop the head into the shift register, clear the bit counter, go to START.
- START: `txd`=0 for one bit period.
- DATA: 8 bits, LSB first, one bit period each.
- STOP: `txd`=1 for one bit period. At the end of the bit period:
  - If FIFO non-empty: pop and go directly to START (no idle gap).
  - Otherwise: set `DONE` and go to IDLE.
- `IRQ` = `IE` & `DONE`.
- A push via `DATA` also clears `DONE`. Push takes priority over a same-cycle `DONE` set, i.e. `DONE` stays 0.

Bit timing:
- The baud counter counts 0..DIV−1 within each bit.
- The bit ends when the counter reaches DIV−1.
- `DIV` is sampled at each bit start. A write mid-bit affects the next bit only.

## Timing
Reset values:
- `txd`=1, `IRQ`=0.
- FIFO empty; state IDLE.
- `CTRL`=0, `DIV`=`DIV_RESET`, `DONE`=0, `OVF`=0.
- `Dout` reflects these values.

Reset mid-frame:
- Frame is aborted and FIFO flushed.
- `txd`=1 from the cycle after the reset edge.

Latencies:
- Write to `DATA` at edge N with IDLE and FIFO empty: count=1 after edge N; pop at edge N+1; `txd` falls after edge N+1.
- Frame length is 10·DIV cycles (11·DIV with parity). Back-to-back frames are contiguous.
- `DONE`/`IRQ` rise on the edge that ends the stop bit.
- Register writes take effect at the write edge; reads are combinational with no latency.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined:
  - `CTRL[1]` is writable.
  - With `PE`=1, a PARITY state follows DATA: one bit period driving even parity (XOR of the 8 data bits).
  - `PE` is sampled at frame start.
- Undefined:
  - `CTRL[1]` is read-only 0.
  - No PARITY state exists.
  - Frame is always 8N1.

## Test plan
- Reset, then read all four registers: `DATA`=0, `CTRL`=0, `STATUS`=0x00000004, `DIV`=434; `txd`=1, `IRQ`=0.
- `DIV`=4, `CTRL`=1, write `DATA`=0xA5:
  - `txd` sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - `DONE`=1 and `IRQ`=1 exactly 40 cycles after the pop edge.
  - A write to `STATUS` drops `IRQ`.
- `DIV`=2, write 9 bytes 0x00..0x08 in consecutive cycles:
  - First byte pops after the 1st write; FIFO then fills.
  - 9th write: accepted if count<8, else `OVF`=1.
  - All accepted bytes are sent back-to-back with no idle gap; `STATUS[11:8]` decrements per frame.
- Write `DIV`=8 mid-bit during a frame with `DIV`=4: current bit stays 4 cycles; following bits are 8 cycles.
- Assert `reset` during DATA bit 3: `txd`=1 next cycle, `STATUS`=0x04, no further frame transmitted.
- With `UART_TX_PARITY_EN`, `CTRL`=3, `DIV`=2, byte 0x07: parity bit 1 between bit7 and stop; frame 22 cycles. Without the macro, `CTRL` reads 1 and the frame is 20 cycles.
